// File: rtl/aes_pkg.sv
// Shared AES-256 types, constants and byte-level transforms used by the
// key schedule and by the cipher round logic.
package aes_pkg;

  localparam int NR     = 14;
  localparam int NWORDS = 4 * (NR + 1);

  typedef logic [0:14][127:0] round_keys_t;

  typedef enum logic [1:0] {KEY_IDLE, KEY_EXPAND, KEY_DONE} key_state_e;
  typedef enum logic [1:0] {CIPH_IDLE, CIPH_ROUND, CIPH_OUT} ciph_state_e;

  // Index 0 is unused; AES-256 only needs Rcon[1..7]
  localparam logic [0:7][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04,
                                      8'h08, 8'h10, 8'h20, 8'h40};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, which maps 0 to 0) followed by
  // the affine transform, so no 256-entry table has to be maintained.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Byte k sits at [127-8k -: 8]; byte (row + 4*col) is state[row][col]
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_expansion.sv
// AES-256 key schedule: captures w0..w7 on start_i, then derives one word
// per cycle into a 60-word register file and flags the round keys valid.
//
// state      | meaning
// KEY_IDLE   | no key loaded since reset
// KEY_EXPAND | generating w[idx], idx = 8..59
// KEY_DONE   | all 60 words present; valid asserts one cycle after entry
module key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         start_i,
  input  logic [255:0] key_i,
  output round_keys_t  round_keys_o,
  output logic         round_keys_valid_o
);

  key_state_e  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [31:0] w_q [0:NWORDS-1];
  logic [31:0] prev_w, sub_in, sub_out, temp_w, new_w;

  // Next word: RotWord/SubWord/Rcon on multiples of 8, SubWord only at 4 mod 8
  always_comb begin
    prev_w  = w_q[idx_q - 6'd1];
    sub_in  = (idx_q[2:0] == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = '0;
    for (int b = 0; b < 4; b++) sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
    temp_w = prev_w;
    if (idx_q[2:0] == 3'd0)      temp_w = sub_out ^ {RCON[idx_q[5:3]], 24'h0};
    else if (idx_q[2:0] == 3'd4) temp_w = sub_out;
    new_w = w_q[idx_q - 6'd8] ^ temp_w;
  end

  // Schedule FSM; a start request always wins and restarts from w8
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      KEY_EXPAND: begin
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'(NWORDS - 1)) state_d = KEY_DONE;
      end
      default: ;
    endcase
    if (start_i) begin
      state_d = KEY_EXPAND;
      idx_d   = 6'd8;
    end
    valid_d = (state_q == KEY_DONE) && !start_i;
  end

  // Schedule state, word index and valid flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= KEY_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Word register file: cipher key on start, then one derived word per cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NWORDS; i++) w_q[i] <= '0;
    end else if (start_i) begin
      for (int i = 0; i < 8; i++) w_q[i] <= key_i[255-32*i -: 32];
    end else if (state_q == KEY_EXPAND) begin
      w_q[idx_q] <= new_w;
    end
  end

  // Round key r is words 4r..4r+3, first word in the top bits
  always_comb begin
    round_keys_o = '0;
    for (int r = 0; r <= NR; r++)
      round_keys_o[r] = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
  end

  assign round_keys_valid_o = valid_q;

endmodule

// File: rtl/aes256_encrypt_core.sv
// Iterative AES-256 ECB encryptor: one round per cycle, one block in flight,
// stream in/out handshakes, key reloads deferred while a block is in flight.
//
// state      | meaning
// CIPH_IDLE  | waiting for a block; ready when keys valid and no key pending
// CIPH_ROUND | applying rounds 1..14, round_q is the round being applied
// CIPH_OUT   | ciphertext presented, held until aes_out_tready
module aes256_encrypt_core
  import aes_pkg::*;
#(
  parameter int ROUND_NUMBER = 14,
  parameter int TDATA_WIDTH  = 128
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [255:0]           aes_key_i,
  input  logic                   aes_key_valid_i,
  input  logic [TDATA_WIDTH-1:0] aes_in_tdata,
  input  logic                   aes_in_tvalid,
  input  logic                   aes_in_tlast,
  output logic                   aes_in_tready,
  output logic [TDATA_WIDTH-1:0] aes_out_tdata,
  output logic                   aes_out_tvalid,
  output logic                   aes_out_tlast,
  input  logic                   aes_out_tready,
  output logic                   round_keys_valid_o
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUND_NUMBER);

  ciph_state_e  cstate_q, cstate_d;
  logic [127:0] data_q, data_d;
  logic [127:0] out_data_q, out_data_d;
  logic [3:0]   round_q, round_d;
  logic         last_q, last_d;
  logic         out_last_q, out_last_d;
  logic         key_valid_q, pending_q, pending_d;
  logic         key_edge, key_start, cipher_idle;
  logic [127:0] sb_sr, round_out;
  round_keys_t  rk;

  // Key request: edge detect, and hold it pending until the cipher is idle.
  // The edge itself also masks ready so a block never starts on stale keys.
  always_comb begin
    cipher_idle   = (cstate_q == CIPH_IDLE);
    key_edge      = aes_key_valid_i && !key_valid_q;
    key_start     = (key_edge || pending_q) && cipher_idle;
    pending_d     = (pending_q || key_edge) && !key_start;
    aes_in_tready = cipher_idle && round_keys_valid_o && !pending_q && !key_edge;
  end

  key_expansion u_key_exp (
    .clk                (clk),
    .resetn             (resetn),
    .start_i            (key_start),
    .key_i              (aes_key_i),
    .round_keys_o       (rk),
    .round_keys_valid_o (round_keys_valid_o)
  );

  // One full round; the final round skips MixColumns
  always_comb begin
    sb_sr     = shift_rows(sub_bytes(data_q));
    round_out = ((round_q == LAST_ROUND) ? sb_sr : mix_columns(sb_sr)) ^ rk[round_q];
  end

  // Cipher FSM next state and datapath updates
  always_comb begin
    cstate_d   = cstate_q;
    data_d     = data_q;
    round_d    = round_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    unique case (cstate_q)
      CIPH_IDLE: begin
        if (aes_in_tvalid && aes_in_tready) begin
          data_d   = aes_in_tdata ^ rk[0];
          last_d   = aes_in_tlast;
          round_d  = 4'd1;
          cstate_d = CIPH_ROUND;
        end
      end
      CIPH_ROUND: begin
        data_d  = round_out;
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND) begin
          out_data_d = round_out;
          out_last_d = last_q;
          cstate_d   = CIPH_OUT;
        end
      end
      CIPH_OUT: begin
        if (aes_out_tready) cstate_d = CIPH_IDLE;
      end
      default: cstate_d = CIPH_IDLE;
    endcase
  end

  // Cipher registers and key request tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cstate_q    <= CIPH_IDLE;
      data_q      <= '0;
      out_data_q  <= '0;
      round_q     <= '0;
      last_q      <= 1'b0;
      out_last_q  <= 1'b0;
      key_valid_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      cstate_q    <= cstate_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      round_q     <= round_d;
      last_q      <= last_d;
      out_last_q  <= out_last_d;
      key_valid_q <= aes_key_valid_i;
      pending_q   <= pending_d;
    end
  end

  assign aes_out_tdata  = out_data_q;
  assign aes_out_tlast  = out_last_q;
  assign aes_out_tvalid = (cstate_q == CIPH_OUT);

endmodule

// File: tb/tb_aes256_encrypt_core.sv
// Scoreboard bench for aes256_encrypt_core: the driver pushes expected
// ciphertexts (known-answer constants or a byte-array AES model), the monitor
// pops and compares whenever the core presents an output.
module tb_aes256_encrypt_core;

  logic         clk = 1'b0;
  logic         resetn;
  logic [255:0] aes_key_i;
  logic         aes_key_valid_i;
  logic [127:0] aes_in_tdata;
  logic         aes_in_tvalid;
  logic         aes_in_tlast;
  logic         aes_in_tready;
  logic [127:0] aes_out_tdata;
  logic         aes_out_tvalid;
  logic         aes_out_tlast;
  logic         aes_out_tready;
  logic         round_keys_valid_o;

  aes256_encrypt_core dut (
    .clk(clk), .resetn(resetn),
    .aes_key_i(aes_key_i), .aes_key_valid_i(aes_key_valid_i),
    .aes_in_tdata(aes_in_tdata), .aes_in_tvalid(aes_in_tvalid),
    .aes_in_tlast(aes_in_tlast), .aes_in_tready(aes_in_tready),
    .aes_out_tdata(aes_out_tdata), .aes_out_tvalid(aes_out_tvalid),
    .aes_out_tlast(aes_out_tlast), .aes_out_tready(aes_out_tready),
    .round_keys_valid_o(round_keys_valid_o)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] KAT_KEY =
    256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4;

  typedef struct {
    logic [127:0] ct;
    logic         last;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           rdy_mode = 0;
  int           ready_viol = 0;
  logic [7:0]   sb [256];
  logic [255:0] cur_key;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // S-box table built by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] m_xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] m_subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [255:0] key, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [127:0] ct;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = m_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = m_xt(rc);
      end else if (i % 8 == 4) begin
        t = m_subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) n[4*c+j] = s[4*((c+j)%4)+j];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
          n[4*c]   = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
          n[4*c+1] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
          n[4*c+2] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
          n[4*c+3] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = n[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- output ready driver ----------------
  initial begin
    aes_out_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       aes_out_tready = 1'b1;
        1:       aes_out_tready = 1'($urandom_range(0, 1));
        default: aes_out_tready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [127:0] held_d;
  logic         held_l;
  bit           seen = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      seen = 1'b0;
    end else if (aes_out_tvalid) begin
      if (!seen) begin
        seen   = 1'b1;
        held_d = aes_out_tdata;
        held_l = aes_out_tlast;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%h required=no_output", aes_out_tdata);
        end else begin
          check_int("latency", cyc - exp_q[0].acc, 14);
        end
      end else begin
        check("hold_data", aes_out_tdata, held_d);
        check("hold_last", 128'(aes_out_tlast), 128'(held_l));
      end
      if (aes_out_tready) begin
        seen = 1'b0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("ciphertext", aes_out_tdata, e.ct);
          check("out_tlast", 128'(aes_out_tlast), 128'(e.last));
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_block(input logic [127:0] pt, input logic last, input int gap,
                            input logic [127:0] exp_ct);
    exp_t x;
    int   k;
    repeat (gap) begin
      @(posedge clk);
      #1;
      aes_in_tvalid = 1'b0;
      aes_in_tdata  = rand128();
      aes_in_tlast  = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    aes_in_tvalid = 1'b1;
    aes_in_tdata  = pt;
    aes_in_tlast  = last;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (aes_in_tready) break;
    end
    if (k == 300) begin
      check_int("accept_timeout", k, 0);
    end else begin
      x.ct   = exp_ct;
      x.last = last;
      x.acc  = cyc + 1;
      exp_q.push_back(x);
      @(posedge clk);
    end
    #1;
    aes_in_tvalid = 1'b0;
    aes_in_tdata  = rand128();
  endtask

  // Call right after the capture edge; returns edges until valid is seen
  task automatic wait_keys(input bit probe, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (round_keys_valid_o) begin
        aes_in_tvalid = 1'b0;
        break;
      end
      if (probe && aes_in_tready) ready_viol++;
      if (lat > 200) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic load_key(input logic [255:0] k, input bit probe, output int lat);
    @(posedge clk);
    #1;
    aes_key_i       = k;
    aes_key_valid_i = 1'b1;
    if (probe) begin
      aes_in_tvalid = 1'b1;
      aes_in_tdata  = rand128();
    end
    @(posedge clk);
    #1;
    aes_key_valid_i = 1'b0;
    wait_keys(probe, lat);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_int("drain", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_tready"},  128'(aes_in_tready), 128'(0));
    check({tag, "_out_tvalid"}, 128'(aes_out_tvalid), 128'(0));
    check({tag, "_out_tdata"},  aes_out_tdata, 128'(0));
    check({tag, "_out_tlast"},  128'(aes_out_tlast), 128'(0));
    check({tag, "_keys_valid"}, 128'(round_keys_valid_o), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int           lat, k;
    logic [127:0] pt;
    logic [255:0] k2;
    build_sbox();
    resetn          = 1'b0;
    aes_key_i       = '0;
    aes_key_valid_i = 1'b0;
    aes_in_tdata    = '0;
    aes_in_tvalid   = 1'b0;
    aes_in_tlast    = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Key expansion with input offered the whole time
    load_key(KAT_KEY, 1'b1, lat);
    cur_key = KAT_KEY;
    check_int("key_exp_latency", lat, 53);
    check_int("tready_during_expand", ready_viol, 0);
    check("rk14", dut.u_key_exp.round_keys_o[14], 128'hFE4890D1E6188D0B046DF344706C631E);

    // Known-answer single block and stream with gaps
    send_block(128'h6BC1BEE22E409F96E93D7E117393172A, 1'b0, 0,
               128'hF3EED1BDB5D2A03C064B5A7E3DB181F8);
    drain();
    send_block(128'hAE2D8A571E03AC9C9EB76FAC45AF8E51, 1'b0, 3,
               128'h591CCB10D410ED26DC5BA74A31362870);
    send_block(128'h30C81C46A35CE411E5FBC1191A0A52EF, 1'b0, 1,
               128'hB6ED21B99CA6F4F9F153E7B1BEAFED1D);
    send_block(128'hF69F2445DF4F9B17AD2B417BE66C3710, 1'b1, 4,
               128'h23304B7A39F9F3FF067D8D8F9E24ECC7);
    drain();

    // Backpressure: hold ready low for 20 cycles while output is presented
    rdy_mode = 2;
    pt = rand128();
    send_block(pt, 1'b1, 0, model_encrypt(cur_key, pt));
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (aes_out_tvalid) break;
    end
    check_int("bp_valid_seen", int'(aes_out_tvalid), 1);
    ready_viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (aes_in_tready) ready_viol++;
    end
    check_int("bp_in_tready_low", ready_viol, 0);
    rdy_mode = 0;
    drain();
    @(posedge clk);
    @(negedge clk);
    check("ready_returns", 128'(aes_in_tready), 128'(1));

    // Randomized stream with random gaps, tlast and output backpressure
    rdy_mode = 1;
    for (int i = 0; i < 25; i++) begin
      pt = rand128();
      send_block(pt, 1'($urandom_range(0, 1)), $urandom_range(0, 3), model_encrypt(cur_key, pt));
    end
    drain();

    // Rekey while a block is in its rounds: deferred until after the output
    rdy_mode = 0;
    k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    pt = rand128();
    send_block(pt, 1'b0, 0, model_encrypt(cur_key, pt));
    repeat (4) @(posedge clk);
    #1;
    aes_key_i       = k2;
    aes_key_valid_i = 1'b1;
    @(posedge clk);
    #1;
    aes_key_valid_i = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (aes_out_tvalid && aes_out_tready) break;
    end
    check("rekey_deferred", 128'(round_keys_valid_o), 128'(1));
    @(posedge clk);
    @(negedge clk);
    check("pending_blocks_input", 128'(aes_in_tready), 128'(0));
    @(posedge clk);
    wait_keys(1'b0, lat);
    check_int("rekey_latency", lat, 53);
    cur_key = k2;
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      pt = rand128();
      send_block(pt, 1'($urandom_range(0, 1)), $urandom_range(0, 2), model_encrypt(cur_key, pt));
    end
    drain();

    // Reset in the middle of a round
    rdy_mode = 0;
    pt = rand128();
    send_block(pt, 1'b1, 0, model_encrypt(cur_key, pt));
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    load_key(KAT_KEY, 1'b0, lat);
    cur_key = KAT_KEY;
    check_int("reload_latency", lat, 53);
    send_block(128'h6BC1BEE22E409F96E93D7E117393172A, 1'b1, 1,
               128'hF3EED1BDB5D2A03C064B5A7E3DB181F8);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
